// File: rtl/tx_ack_timeout_tracker_if.sv
// Retransmit request channel between the ACK/timeout tracker and the TX
// retransmit scheduler.
//   rt_req_val      : a flow has a pending fast retransmit or timeout
//   rt_req_flowid   : flow to retransmit
//   rt_req_timeout  : 1 = timeout, 0 = fast retransmit
//   rt_req_ack_num  : current ACK number of the flow (retransmit start)
//   rt_req_rdy      : scheduler accepts the request
// master = tracker side, slave = scheduler side.
interface tx_ack_timeout_tracker_if #(
    parameter int FLOW_ID_W = 3,
    parameter int ACK_NUM_W = 32
);
    logic                 rt_req_val;
    logic [FLOW_ID_W-1:0] rt_req_flowid;
    logic                 rt_req_timeout;
    logic [ACK_NUM_W-1:0] rt_req_ack_num;
    logic                 rt_req_rdy;

    modport master (
        output rt_req_val,
        output rt_req_flowid,
        output rt_req_timeout,
        output rt_req_ack_num,
        input  rt_req_rdy
    );

    modport slave (
        input  rt_req_val,
        input  rt_req_flowid,
        input  rt_req_timeout,
        input  rt_req_ack_num,
        output rt_req_rdy
    );
endinterface

// File: rtl/tx_ack_timeout_tracker.sv
// Per-flow transmit-side ACK tracker. Tracks the cumulative ACK number,
// duplicate-ACK count, next-send sequence and a retransmit timer for every
// flow. Duplicate-ACK threshold hits raise rt_pending, expired timers raise
// timeout_pending; pending flows are offered round-robin on rt_req.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   init_val/init_flowid/init_seq_num: (re)initialise one flow
//   ack_val/ack_flowid/ack_num       : ACK from the RX path (always accepted)
//   send_val/send_flowid/send_seq_end: segment sent by TX (always accepted)
//   rt_req                           : retransmit request channel (master)
module tx_ack_timeout_tracker #(
    parameter int FLOW_ID_W          = 3,
    parameter int ACK_NUM_W          = 32,
    parameter int RT_ACK_THRESHOLD_W = 2,
    parameter int RT_ACK_THRESHOLD   = 3,
    parameter int TIMESTAMP_W        = 32,
    parameter int RT_TIMEOUT_CYCLES  = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_val,
    input  logic [FLOW_ID_W-1:0] init_flowid,
    input  logic [ACK_NUM_W-1:0] init_seq_num,
    input  logic                 ack_val,
    input  logic [FLOW_ID_W-1:0] ack_flowid,
    input  logic [ACK_NUM_W-1:0] ack_num,
    input  logic                 send_val,
    input  logic [FLOW_ID_W-1:0] send_flowid,
    input  logic [ACK_NUM_W-1:0] send_seq_end,
    tx_ack_timeout_tracker_if.master rt_req
);
    localparam int NUM_FLOWS = 2**FLOW_ID_W;
    localparam int CNT_W     = RT_ACK_THRESHOLD_W + 1;

    // Per-flow state and next-state
    logic [ACK_NUM_W-1:0]          ack_num_r [NUM_FLOWS];
    logic [ACK_NUM_W-1:0]          ack_num_nx_s [NUM_FLOWS];
    logic [ACK_NUM_W-1:0]          snd_nxt_r [NUM_FLOWS];
    logic [ACK_NUM_W-1:0]          snd_nxt_nx_s [NUM_FLOWS];
    logic [RT_ACK_THRESHOLD_W-1:0] dup_cnt_r [NUM_FLOWS];
    logic [RT_ACK_THRESHOLD_W-1:0] dup_cnt_nx_s [NUM_FLOWS];
    logic [TIMESTAMP_W-1:0]        ts_r [NUM_FLOWS];
    logic [TIMESTAMP_W-1:0]        ts_nx_s [NUM_FLOWS];
    logic [NUM_FLOWS-1:0]          armed_r, armed_nx_s;
    logic [NUM_FLOWS-1:0]          rt_pend_r, rt_pend_nx_s;
    logic [NUM_FLOWS-1:0]          to_pend_r, to_pend_nx_s;

    // Shared counters and arbiter state
    logic [TIMESTAMP_W-1:0] now_r;
    logic [FLOW_ID_W-1:0]   scan_ptr_r;
    logic [FLOW_ID_W-1:0]   arb_ptr_r;     // first flow considered next
    logic [FLOW_ID_W-1:0]   hold_flow_r;
    logic                   hold_to_r;
    logic                   lock_r;

    // Per-flow event decode
    logic [NUM_FLOWS-1:0] init_hit_s, ack_hit_s, send_hit_s;
    logic [NUM_FLOWS-1:0] ack_new_s, ack_dup_s, scan_hit_s;
    logic [ACK_NUM_W-1:0] delta_s;

    // Arbiter signals
    logic [NUM_FLOWS-1:0] flag_s;
    logic [FLOW_ID_W-1:0] idx_s, pick_s, grant_s;
    logic                 found_s, locked_s, val_s, to_s, hs_s;

    // Decode which flow each input touches and classify the ACK.
    always_comb begin
        init_hit_s = '0;
        ack_hit_s  = '0;
        send_hit_s = '0;
        ack_new_s  = '0;
        ack_dup_s  = '0;
        scan_hit_s = '0;
        delta_s    = '0;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            init_hit_s[f] = init_val && (init_flowid == FLOW_ID_W'(f));
            ack_hit_s[f]  = ack_val  && (ack_flowid  == FLOW_ID_W'(f));
            send_hit_s[f] = send_val && (send_flowid == FLOW_ID_W'(f));
            // Serial-number arithmetic: sign bit of the difference decides
            // whether the ACK moves forward across the wrap point.
            delta_s       = ack_num - ack_num_r[f];
            ack_new_s[f]  = ack_hit_s[f] && !delta_s[ACK_NUM_W-1] && (delta_s != '0);
            ack_dup_s[f]  = ack_hit_s[f] && (delta_s == '0) && armed_r[f];
            scan_hit_s[f] = (scan_ptr_r == FLOW_ID_W'(f)) && armed_r[f] &&
                            ((now_r - ts_r[f]) >= TIMESTAMP_W'(RT_TIMEOUT_CYCLES));
        end
    end

    // Round-robin pick among flagged flows, with the grant locked while stalled.
    always_comb begin
        flag_s  = rt_pend_r | to_pend_r;
        found_s = 1'b0;
        pick_s  = '0;
        idx_s   = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            idx_s = arb_ptr_r + FLOW_ID_W'(i);
            if (!found_s && flag_s[idx_s]) begin
                found_s = 1'b1;
                pick_s  = idx_s;
            end else begin
                found_s = found_s;
            end
        end
        // A held request is dropped only if its flow lost both flags
        // (e.g. re-initialised) while waiting.
        locked_s = lock_r && flag_s[hold_flow_r];
        grant_s  = locked_s ? hold_flow_r : pick_s;
        val_s    = locked_s || found_s;
        to_s     = locked_s ? hold_to_r : to_pend_r[pick_s];
        hs_s     = val_s && rt_req.rt_req_rdy;
    end

    assign rt_req.rt_req_val     = val_s;
    assign rt_req.rt_req_flowid  = grant_s;
    assign rt_req.rt_req_timeout = to_s;
    assign rt_req.rt_req_ack_num = ack_num_r[grant_s];

    // Per-flow next state: scan, handshake clear, then init -> ACK -> send.
    always_comb begin
        ack_num_nx_s = ack_num_r;
        snd_nxt_nx_s = snd_nxt_r;
        dup_cnt_nx_s = dup_cnt_r;
        ts_nx_s      = ts_r;
        armed_nx_s   = armed_r;
        rt_pend_nx_s = rt_pend_r;
        to_pend_nx_s = to_pend_r;
        for (int f = 0; f < NUM_FLOWS; f++) begin
            // Clear first so that a flag set in the same cycle survives.
            if (hs_s && (grant_s == FLOW_ID_W'(f))) begin
                rt_pend_nx_s[f] = 1'b0;
                to_pend_nx_s[f] = 1'b0;
            end else begin
                rt_pend_nx_s[f] = rt_pend_r[f];
            end

            // Scan hits on a flow touched this cycle wait for the next lap.
            if (scan_hit_s[f] && !(init_hit_s[f] || ack_hit_s[f] || send_hit_s[f])) begin
                to_pend_nx_s[f] = 1'b1;
                armed_nx_s[f]   = 1'b0;
                dup_cnt_nx_s[f] = '0;
            end else begin
                armed_nx_s[f] = armed_r[f];
            end

            if (init_hit_s[f]) begin
                ack_num_nx_s[f] = init_seq_num;
                snd_nxt_nx_s[f] = init_seq_num;
                dup_cnt_nx_s[f] = '0;
                armed_nx_s[f]   = 1'b0;
                rt_pend_nx_s[f] = 1'b0;
                to_pend_nx_s[f] = 1'b0;
            end else begin
                if (ack_new_s[f]) begin
                    ack_num_nx_s[f] = ack_num;
                    dup_cnt_nx_s[f] = '0;
                    rt_pend_nx_s[f] = 1'b0;
                    if (ack_num == snd_nxt_r[f]) begin
                        armed_nx_s[f]   = 1'b0;
                        to_pend_nx_s[f] = 1'b0;
                    end else begin
                        ts_nx_s[f]    = now_r;
                        armed_nx_s[f] = 1'b1;
                    end
                end else if (ack_dup_s[f]) begin
                    if (({1'b0, dup_cnt_r[f]} + CNT_W'(1)) == CNT_W'(RT_ACK_THRESHOLD)) begin
                        rt_pend_nx_s[f] = 1'b1;
                        dup_cnt_nx_s[f] = '0;
                    end else begin
                        dup_cnt_nx_s[f] = dup_cnt_r[f] + RT_ACK_THRESHOLD_W'(1);
                    end
                end else begin
                    ack_num_nx_s[f] = ack_num_r[f];
                end

                // Arming looks at the timer as left by the ACK update.
                if (send_hit_s[f]) begin
                    snd_nxt_nx_s[f] = send_seq_end;
                    if (!armed_nx_s[f]) begin
                        armed_nx_s[f] = 1'b1;
                        ts_nx_s[f]    = now_r;
                    end else begin
                        ts_nx_s[f] = ts_nx_s[f];
                    end
                end else begin
                    snd_nxt_nx_s[f] = snd_nxt_nx_s[f];
                end
            end
        end
    end

    // Per-flow state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < NUM_FLOWS; f++) begin
                ack_num_r[f] <= '0;
                snd_nxt_r[f] <= '0;
                dup_cnt_r[f] <= '0;
                ts_r[f]      <= '0;
            end
            armed_r   <= '0;
            rt_pend_r <= '0;
            to_pend_r <= '0;
        end else begin
            ack_num_r <= ack_num_nx_s;
            snd_nxt_r <= snd_nxt_nx_s;
            dup_cnt_r <= dup_cnt_nx_s;
            ts_r      <= ts_nx_s;
            armed_r   <= armed_nx_s;
            rt_pend_r <= rt_pend_nx_s;
            to_pend_r <= to_pend_nx_s;
        end
    end

    // Free-running time base, timer scan pointer and arbiter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            now_r       <= '0;
            scan_ptr_r  <= '0;
            arb_ptr_r   <= '0;
            hold_flow_r <= '0;
            hold_to_r   <= 1'b0;
            lock_r      <= 1'b0;
        end else begin
            now_r       <= now_r + TIMESTAMP_W'(1);
            scan_ptr_r  <= scan_ptr_r + FLOW_ID_W'(1);
            arb_ptr_r   <= hs_s ? (grant_s + FLOW_ID_W'(1)) : arb_ptr_r;
            hold_flow_r <= grant_s;
            hold_to_r   <= to_s;
            lock_r      <= val_s && !rt_req.rt_req_rdy;
        end
    end
endmodule
